// File: rtl/rfs_pkg.sv
// Shared types and sizing helpers for the range frame sequencer.
// No logic, so no latency. No flow control of its own.
// Users of this package do the backpressure.
package rfs_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2,
        DRAIN = 2'd3
    } rfs_state_t;

    localparam int RFS_DEPTH_DEFAULT = 16;
    localparam int RFS_PTR_W         = $clog2(RFS_DEPTH_DEFAULT);

    function automatic int rfs_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/rfs_frame_buffer.sv
// Frame store: DEPTH x WIDTH registers, one synchronous write port and one asynchronous read port.
// Write lands at the next edge. Reads are combinational from the register array.
// No backpressure; the caller sequences writes and reads. Contents are not reset.
module rfs_frame_buffer
    import rfs_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = RFS_DEPTH_DEFAULT,
    parameter int PW    = rfs_ptr_w(DEPTH)
) (
    input  logic             clock,
    input  logic             i_wr_en,
    input  logic [PW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic [PW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_dat
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/range_frame_sequencer.sv
// Buffers one valid/ready frame and replays it as an unbroken burst to the range finder.
// rf_go in the cycle after the closing sample is accepted; N burst cycles + 1 gap cycle.
// s_ready is low during burst and gap. RFS_FRAME_COUNT_EN builds the burst counter.
module range_frame_sequencer
    import rfs_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [WIDTH-1:0] rf_data,
    output logic             rf_go,
    output logic             rf_finish,
    output logic             overflow,
    output logic             short_frame,
    output logic [7:0]       frame_count
);

    localparam int            PW       = rfs_ptr_w(DEPTH);
    localparam logic [PW-1:0] PTR_MAX  = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   LEN_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   LEN_FULL = (PW + 1)'(DEPTH);

    rfs_state_t       r_state;
    rfs_state_t       w_state_nxt;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_len;
    logic             r_drain;
    logic             r_overflow;
    logic             r_short;
    logic [WIDTH-1:0] w_rd_dat;
    logic             w_xfer;
    logic             w_fill_xfer;
    logic             w_short;
    logic             w_close;
    logic             w_trunc;
    logic             w_rd_last;

    assign s_ready     = rst_n && ((r_state == FILL) || (r_state == DRAIN));
    assign w_xfer      = s_valid && s_ready;
    assign w_fill_xfer = w_xfer && (r_state == FILL);
    assign w_short     = w_fill_xfer && s_last && (r_wr_ptr == '0);
    assign w_close     = w_fill_xfer && s_last && (r_wr_ptr != '0);
    assign w_trunc     = w_fill_xfer && !s_last && (r_wr_ptr == PTR_MAX);
    assign w_rd_last   = ({1'b0, r_rd_ptr} == (r_len - LEN_ONE));

    rfs_frame_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_buf (
        .clock     (clock),
        .i_wr_en   (w_fill_xfer),
        .i_wr_addr (r_wr_ptr),
        .i_wr_dat  (s_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_dat  (w_rd_dat)
    );

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        rf_data     = '0;
        rf_go       = 1'b0;
        rf_finish   = 1'b0;
        unique case (r_state)
            FILL: begin
                if (w_close || w_trunc) begin
                    w_state_nxt = BURST;
                end
            end
            BURST: begin
                rf_data   = w_rd_dat;
                rf_go     = (r_rd_ptr == '0);
                rf_finish = w_rd_last;
                if (w_rd_last) begin
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                w_state_nxt = r_drain ? DRAIN : FILL;
            end
            DRAIN: begin
                if (w_xfer && s_last) begin
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_len      <= '0;
            r_drain    <= 1'b0;
            r_overflow <= 1'b0;
            r_short    <= 1'b0;
        end else begin
            r_overflow <= w_trunc;
            r_short    <= w_short;
            unique case (r_state)
                FILL: begin
                    if (w_close) begin
                        r_len <= {1'b0, r_wr_ptr} + LEN_ONE;
                    end else if (w_trunc) begin
                        r_len   <= LEN_FULL;
                        r_drain <= 1'b1;
                    end else if (w_fill_xfer && !w_short) begin
                        r_wr_ptr <= r_wr_ptr + PTR_ONE;
                    end
                end
                BURST: begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
                GAP: begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end
                DRAIN: begin
                    if (w_xfer && s_last) begin
                        r_drain <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign overflow    = r_overflow;
    assign short_frame = r_short;

`ifdef RFS_FRAME_COUNT_EN
    logic [7:0] r_frame_count;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_frame_count <= 8'd0;
        end else if (rf_finish) begin
            r_frame_count <= r_frame_count + 8'd1;
        end
    end

    assign frame_count = r_frame_count;
`else
    assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_range_frame_sequencer.sv
// Randomized and directed stimulus checked cycle by cycle against a frame-level model.
// The model turns each closed frame into a list of expected burst cycles.
module tb_range_frame_sequencer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clock = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic [WIDTH-1:0] rf_data;
    logic             rf_go;
    logic             rf_finish;
    logic             overflow;
    logic             short_frame;
    logic [7:0]       frame_count;

    always #5 clock = ~clock;

    range_frame_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .rf_data     (rf_data),
        .rf_go       (rf_go),
        .rf_finish   (rf_finish),
        .overflow    (overflow),
        .short_frame (short_frame),
        .frame_count (frame_count)
    );

    typedef struct packed {
        logic [7:0] dat;
        logic       go;
        logic       fin;
        logic       rdy;
        logic       ovf;
        logic       sht;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  m_frame[$];
    logic [7:0]  stim[$];
    bit          m_drain = 1'b0;
    int unsigned m_cnt   = 0;
    int          checks  = 0;
    int          errors  = 0;

    function automatic exp_t mk(input logic [7:0] d, input logic g, input logic f,
                                input logic r, input logic o, input logic s);
        exp_t e;
        e.dat = d; e.go = g; e.fin = f; e.rdy = r; e.ovf = o; e.sht = s;
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_burst(input logic ovf);
        int n;
        n = m_frame.size();
        for (int i = 0; i < n; i++)
            exp_q.push_back(mk(m_frame[i], i == 0, i == n - 1, 1'b0, ovf && (i == 0), 1'b0));
        exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        m_frame.delete();
    endtask

    task automatic model_accept(input logic [7:0] d, input logic l);
        if (m_drain) begin
            if (l) m_drain = 1'b0;
        end else begin
            m_frame.push_back(d);
            if (l) begin
                if (m_frame.size() == 1) begin
                    exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
                    m_frame.delete();
                end else begin
                    push_burst(1'b0);
                end
            end else if (m_frame.size() == DEPTH) begin
                push_burst(1'b1);
                m_drain = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_frame.delete();
        m_drain = 1'b0;
        m_cnt   = 0;
    endtask

    // One clock: check the current cycle, then drive inputs for the next edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic l,
                         input logic rn, output logic acc);
        exp_t       e;
        logic [7:0] fc_exp;
        @(posedge clock);
        #1;
        e = (exp_q.size() != 0) ? exp_q[0] : mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef RFS_FRAME_COUNT_EN
        fc_exp = 8'(m_cnt);
`else
        fc_exp = 8'h00;
`endif
        check_eq("s_ready",     32'(s_ready),     32'(rst_n & e.rdy));
        check_eq("rf_data",     32'(rf_data),     32'(e.dat));
        check_eq("rf_go",       32'(rf_go),       32'(e.go));
        check_eq("rf_finish",   32'(rf_finish),   32'(e.fin));
        check_eq("overflow",    32'(overflow),    32'(e.ovf));
        check_eq("short_frame", 32'(short_frame), 32'(e.sht));
        check_eq("frame_count", 32'(frame_count), 32'(fc_exp));
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (e.fin) m_cnt++;
        s_valid = v;
        s_data  = d;
        s_last  = l;
        rst_n   = rn;
        acc     = rn && v && e.rdy;
        if (!rn) model_reset();
        else if (acc) model_accept(d, l);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++)
            cycle(1'b0, 8'($urandom()), 1'($urandom()), 1'b1, acc);
    endtask

    task automatic send_sample(input logic [7:0] d, input logic l, input int gap_max);
        logic acc;
        int   tries;
        if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 64) begin
            cycle(1'b1, d, l, 1'b1, acc);
            tries++;
        end
        if (!acc) check_eq("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_stim(input int gap_max);
        for (int i = 0; i < stim.size(); i++)
            send_sample(stim[i], i == stim.size() - 1, gap_max);
        stim.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   n;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        idle(2);

        stim = '{8'd5, 8'd9, 8'd2, 8'd7};
        send_stim(0);
        idle(6);

        stim = '{8'd42};
        send_stim(0);
        idle(3);

        for (int i = 0; i < 20; i++) stim.push_back(8'(i));
        send_stim(0);
        stim = '{8'd3, 8'd1};
        send_stim(0);
        idle(4);

        // Source holds s_valid high across several back-to-back frames.
        for (int f = 0; f < 3; f++) begin
            n = 2 + f * 3;
            for (int i = 0; i < n; i++) stim.push_back(8'($urandom()));
            send_stim(0);
        end
        idle(12);

        for (int i = 1; i <= 6; i++) stim.push_back(8'(i * 11));
        send_stim(0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        stim = '{8'd4, 8'd8};
        send_stim(0);
        idle(5);

        for (int f = 0; f < 3; f++) begin
            stim = '{8'(f + 100), 8'(f + 200), 8'(f + 50)};
            send_stim(0);
        end
        idle(12);

        for (int f = 0; f < 40; f++) begin
            n = int'($urandom_range(22, 1));
            for (int i = 0; i < n; i++) stim.push_back(8'($urandom()));
            send_stim(int'($urandom_range(2, 0)));
        end
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
